// File: rtl/rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter
// Sequencer/arbiter for the register file's single general-purpose write
// port. Merges the writeback stage (optionally dual-destination) with an
// external requester (interrupt/debug context load). Dual results are split
// over two cycles with writeback stalled in between; the external requester
// is guaranteed a grant after at most STARVE_MAX denied cycles (plus one
// possible SECOND cycle). The register file commits on the falling edge, so
// every write issued here lands in the middle of the following cycle.
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   wb_valid_i, wb_dual_i       WB write request / request carries write B
//   wb_addr_a_i, wb_data_a_i    WB write A
//   wb_addr_b_i, wb_data_b_i    WB write B (dual only)
//   ext_req_i                   external request, held until granted
//   ext_addr_i, ext_data_i      external write
//   stall_o                     combinational; WB must hold its request
//   ext_gnt_o                   registered pulse; ext write issued
//   data_write1_o               registered register-file write enable
//   write_addr1_o, write_data1_o registered write address / data
//   pend_valid_o/addr_o/data_o  latched B write still to issue (forwarding)
//   addr_err_o                  registered pulse; issued write suppressed
//                               because its address was >= REG_NUMBER
// ---------------------------------------------------------------------------
module rf_write_arbiter #(
   parameter int unsigned REG_SIZE   = 16,
   parameter int unsigned ADDR_W     = 4,
   parameter int unsigned REG_NUMBER = 8,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic                clk,
   input  logic                rst_n,

   input  logic                wb_valid_i,
   input  logic                wb_dual_i,
   input  logic [ADDR_W-1:0]   wb_addr_a_i,
   input  logic [ADDR_W-1:0]   wb_addr_b_i,
   input  logic [REG_SIZE-1:0] wb_data_a_i,
   input  logic [REG_SIZE-1:0] wb_data_b_i,

   input  logic                ext_req_i,
   input  logic [ADDR_W-1:0]   ext_addr_i,
   input  logic [REG_SIZE-1:0] ext_data_i,

   output logic                stall_o,
   output logic                ext_gnt_o,
   output logic                data_write1_o,
   output logic [ADDR_W-1:0]   write_addr1_o,
   output logic [REG_SIZE-1:0] write_data1_o,
   output logic                pend_valid_o,
   output logic [ADDR_W-1:0]   pend_addr_o,
   output logic [REG_SIZE-1:0] pend_data_o,
   output logic                addr_err_o
);

   localparam int unsigned CNT_W = 4;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      SECOND = 1'b1
   } state_e;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     starve_q, starve_d;

   // Issue decode produced by the output process
   logic                 force_ext_c;
   logic                 issue_c;
   logic                 grant_c;
   logic                 latch_b_c;
   logic                 addr_ok_c;
   logic [ADDR_W-1:0]    issue_addr_c;
   logic [REG_SIZE-1:0]  issue_data_c;

   // Registered port / pending state
   logic                 wr_en_q;
   logic [ADDR_W-1:0]    wr_addr_q;
   logic [REG_SIZE-1:0]  wr_data_q;
   logic                 ext_gnt_q;
   logic                 addr_err_q;
   logic                 pend_valid_q;
   logic [ADDR_W-1:0]    pend_addr_q;
   logic [REG_SIZE-1:0]  pend_data_q;

   // Ext wins outright once it has been denied STARVE_MAX cycles in a row
   assign force_ext_c = (state_q == IDLE) && ext_req_i &&
                        (starve_q == CNT_W'(STARVE_MAX));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
      end
   end

   // Next-state logic: FSM and starvation counter
   always_comb begin
      state_d  = state_q;
      starve_d = starve_q;

      case (state_q)
         IDLE: begin
            if (!force_ext_c && wb_valid_i && wb_dual_i) begin
               state_d = SECOND;
            end
         end
         SECOND: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Counts consecutive denied cycles, including a SECOND cycle
      if (!ext_req_i || grant_c) begin
         starve_d = '0;
      end else if (starve_q != CNT_W'(STARVE_MAX)) begin
         starve_d = starve_q + CNT_W'(1);
      end
   end

   // Output logic: who owns the port this cycle, and the stall to WB
   always_comb begin
      issue_c      = 1'b0;
      grant_c      = 1'b0;
      latch_b_c    = 1'b0;
      issue_addr_c = '0;
      issue_data_c = '0;
      stall_o      = 1'b0;

      case (state_q)
         IDLE: begin
            if (force_ext_c) begin
               issue_c      = 1'b1;
               grant_c      = 1'b1;
               issue_addr_c = ext_addr_i;
               issue_data_c = ext_data_i;
               stall_o      = 1'b1;
            end else if (wb_valid_i) begin
               issue_c      = 1'b1;
               issue_addr_c = wb_addr_a_i;
               issue_data_c = wb_data_a_i;
               latch_b_c    = wb_dual_i;
            end else if (ext_req_i) begin
               issue_c      = 1'b1;
               grant_c      = 1'b1;
               issue_addr_c = ext_addr_i;
               issue_data_c = ext_data_i;
            end
         end
         SECOND: begin
            issue_c      = 1'b1;
            issue_addr_c = pend_addr_q;
            issue_data_c = pend_data_q;
            stall_o      = 1'b1;
         end
         default: begin
            stall_o      = 1'b0;
         end
      endcase
   end

   // Upper addresses hold the PC halves and are never written via this port
   assign addr_ok_c = (32'(issue_addr_c) < REG_NUMBER);

   // Write-port registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         ext_gnt_q  <= 1'b0;
         addr_err_q <= 1'b0;
      end else begin
         wr_en_q    <= issue_c && addr_ok_c;
         addr_err_q <= issue_c && !addr_ok_c;
         ext_gnt_q  <= grant_c;
         // Address/data load even when suppressed so the bad target is visible
         if (issue_c) begin
            wr_addr_q <= issue_addr_c;
            wr_data_q <= issue_data_c;
         end
      end
   end

   // Pending B write; reset discards it before it can issue
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_valid_q <= 1'b0;
         pend_addr_q  <= '0;
         pend_data_q  <= '0;
      end else if (latch_b_c) begin
         pend_valid_q <= 1'b1;
         pend_addr_q  <= wb_addr_b_i;
         pend_data_q  <= wb_data_b_i;
      end else if (state_q == SECOND) begin
         pend_valid_q <= 1'b0;
      end
   end

   assign data_write1_o = wr_en_q;
   assign write_addr1_o = wr_addr_q;
   assign write_data1_o = wr_data_q;
   assign ext_gnt_o     = ext_gnt_q;
   assign addr_err_o    = addr_err_q;
   assign pend_valid_o  = pend_valid_q;
   assign pend_addr_o   = pend_addr_q;
   assign pend_data_o   = pend_data_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_write_arbiter
// Directed scenarios followed by a randomized run checked against a
// transaction-level model (queue of outstanding B writes, denied-cycle count,
// register-file image).
// ---------------------------------------------------------------------------
module tb_rf_write_arbiter;

   localparam int unsigned REG_SIZE   = 16;
   localparam int unsigned ADDR_W     = 4;
   localparam int unsigned REG_NUMBER = 8;
   localparam int unsigned STARVE_MAX = 4;

   typedef struct packed {
      logic [ADDR_W-1:0]   a;
      logic [REG_SIZE-1:0] d;
   } wr_t;

   logic                clk;
   logic                rst_n;
   logic                wb_valid_i, wb_dual_i;
   logic [ADDR_W-1:0]   wb_addr_a_i, wb_addr_b_i;
   logic [REG_SIZE-1:0] wb_data_a_i, wb_data_b_i;
   logic                ext_req_i;
   logic [ADDR_W-1:0]   ext_addr_i;
   logic [REG_SIZE-1:0] ext_data_i;
   logic                stall_o, ext_gnt_o, data_write1_o;
   logic [ADDR_W-1:0]   write_addr1_o;
   logic [REG_SIZE-1:0] write_data1_o;
   logic                pend_valid_o;
   logic [ADDR_W-1:0]   pend_addr_o;
   logic [REG_SIZE-1:0] pend_data_o;
   logic                addr_err_o;

   int checks = 0;
   int errors = 0;

   logic [REG_SIZE-1:0] rf [16];

   rf_write_arbiter #(
      .REG_SIZE  (REG_SIZE),
      .ADDR_W    (ADDR_W),
      .REG_NUMBER(REG_NUMBER),
      .STARVE_MAX(STARVE_MAX)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .wb_valid_i   (wb_valid_i),
      .wb_dual_i    (wb_dual_i),
      .wb_addr_a_i  (wb_addr_a_i),
      .wb_addr_b_i  (wb_addr_b_i),
      .wb_data_a_i  (wb_data_a_i),
      .wb_data_b_i  (wb_data_b_i),
      .ext_req_i    (ext_req_i),
      .ext_addr_i   (ext_addr_i),
      .ext_data_i   (ext_data_i),
      .stall_o      (stall_o),
      .ext_gnt_o    (ext_gnt_o),
      .data_write1_o(data_write1_o),
      .write_addr1_o(write_addr1_o),
      .write_data1_o(write_data1_o),
      .pend_valid_o (pend_valid_o),
      .pend_addr_o  (pend_addr_o),
      .pend_data_o  (pend_data_o),
      .addr_err_o   (addr_err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file image: commits on the falling edge
   always @(negedge clk) begin
      if (data_write1_o) rf[write_addr1_o] <= write_data1_o;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic idle_inputs();
      wb_valid_i = 1'b0; wb_dual_i = 1'b0;
      wb_addr_a_i = '0; wb_addr_b_i = '0; wb_data_a_i = '0; wb_data_b_i = '0;
      ext_req_i = 1'b0; ext_addr_i = '0; ext_data_i = '0;
   endtask

   task automatic wb_req(input logic dual, input logic [3:0] aa, input logic [15:0] da,
                         input logic [3:0] ab, input logic [15:0] db);
      wb_valid_i = 1'b1; wb_dual_i = dual;
      wb_addr_a_i = aa; wb_data_a_i = da; wb_addr_b_i = ab; wb_data_b_i = db;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // -------------------------------------------------------------------------
   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      #3;
      checks++; if (data_write1_o !== 1'b0) begin errors++; $display("FAIL rst_we got %0b exp 0", data_write1_o); end
      checks++; if (write_addr1_o !== 4'd0 || write_data1_o !== 16'h0) begin errors++; $display("FAIL rst_port got %0h/%0h exp 0/0", write_addr1_o, write_data1_o); end
      checks++; if (ext_gnt_o !== 1'b0 || addr_err_o !== 1'b0) begin errors++; $display("FAIL rst_pulses got %0b%0b exp 00", ext_gnt_o, addr_err_o); end
      checks++; if (pend_valid_o !== 1'b0 || pend_addr_o !== 4'd0 || pend_data_o !== 16'h0) begin errors++; $display("FAIL rst_pend got %0b/%0h/%0h exp 0/0/0", pend_valid_o, pend_addr_o, pend_data_o); end
      checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rst_stall got %0b exp 0", stall_o); end
      @(negedge clk); rst_n = 1'b1;
      wb_req(1'b1, 4'd1, 16'h1111, 4'd2, 16'h2222);
      tick();
      wb_valid_i = 1'b0; wb_dual_i = 1'b0;
      checks++; if (pend_valid_o !== 1'b1 || write_addr1_o !== 4'd1) begin errors++; $display("FAIL rst_dual_a got pv=%0b addr=%0h exp 1/1", pend_valid_o, write_addr1_o); end
      #5;  // past the falling edge that commits A
      rst_n = 1'b0;
      #1;
      checks++; if (data_write1_o !== 1'b0 || pend_valid_o !== 1'b0 || write_addr1_o !== 4'd0 || write_data1_o !== 16'h0) begin errors++; $display("FAIL rst_mid_second got we=%0b pv=%0b addr=%0h data=%0h exp 0", data_write1_o, pend_valid_o, write_addr1_o, write_data1_o); end
      checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rst_mid_stall got %0b exp 0", stall_o); end
      tick();
      @(negedge clk); #1;
      checks++; if (rf[2] !== 16'h0) begin errors++; $display("FAIL rst_b_discard got R2=%0h exp 0", rf[2]); end
      checks++; if (rf[1] !== 16'h1111) begin errors++; $display("FAIL rst_a_commit got R1=%0h exp 1111", rf[1]); end
      rst_n = 1'b1;
      tick();
   endtask

   // -------------------------------------------------------------------------
   task automatic test_single();
      wb_req(1'b0, 4'd3, 16'hBEEF, 4'd0, 16'h0);
      #1;
      checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL single_stall got %0b exp 0", stall_o); end
      tick();
      idle_inputs();
      checks++; if (data_write1_o !== 1'b1 || write_addr1_o !== 4'd3 || write_data1_o !== 16'hBEEF) begin errors++; $display("FAIL single_write got we=%0b %0h/%0h exp 1 3/beef", data_write1_o, write_addr1_o, write_data1_o); end
      checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL single_stall_after got %0b exp 0", stall_o); end
      tick();
      checks++; if (data_write1_o !== 1'b0 || write_addr1_o !== 4'd3 || write_data1_o !== 16'hBEEF) begin errors++; $display("FAIL single_hold got we=%0b %0h/%0h exp 0 3/beef", data_write1_o, write_addr1_o, write_data1_o); end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_dual();
      wb_req(1'b1, 4'd4, 16'h0004, 4'd5, 16'h0005);
      #1;
      checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL dual_stall_pre got %0b exp 0", stall_o); end
      tick();
      checks++; if (data_write1_o !== 1'b1 || write_addr1_o !== 4'd4 || write_data1_o !== 16'h0004) begin errors++; $display("FAIL dual_a got we=%0b %0h/%0h exp 1 4/0004", data_write1_o, write_addr1_o, write_data1_o); end
      checks++; if (pend_valid_o !== 1'b1 || pend_addr_o !== 4'd5 || pend_data_o !== 16'h0005) begin errors++; $display("FAIL dual_pend got %0b/%0h/%0h exp 1/5/0005", pend_valid_o, pend_addr_o, pend_data_o); end
      wb_req(1'b0, 4'd3, 16'h0033, 4'd0, 16'h0);  // next request, held under stall
      #1;
      checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL dual_stall got %0b exp 1", stall_o); end
      tick();
      checks++; if (data_write1_o !== 1'b1 || write_addr1_o !== 4'd5 || write_data1_o !== 16'h0005) begin errors++; $display("FAIL dual_b got we=%0b %0h/%0h exp 1 5/0005", data_write1_o, write_addr1_o, write_data1_o); end
      checks++; if (pend_valid_o !== 1'b0 || stall_o !== 1'b0) begin errors++; $display("FAIL dual_release got pv=%0b stall=%0b exp 0/0", pend_valid_o, stall_o); end
      tick();
      idle_inputs();
      checks++; if (data_write1_o !== 1'b1 || write_addr1_o !== 4'd3 || write_data1_o !== 16'h0033) begin errors++; $display("FAIL dual_next got we=%0b %0h/%0h exp 1 3/0033", data_write1_o, write_addr1_o, write_data1_o); end
      tick();
   endtask

   // -------------------------------------------------------------------------
   task automatic test_starvation();
      ext_req_i = 1'b1; ext_addr_i = 4'd6; ext_data_i = 16'h6666;
      for (int i = 0; i < int'(STARVE_MAX); i++) begin
         wb_req(1'b0, 4'(i), 16'h1000 + 16'(i), 4'd0, 16'h0);
         #1;
         checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL starve_stall%0d got %0b exp 0", i, stall_o); end
         tick();
         checks++; if (data_write1_o !== 1'b1 || write_addr1_o !== 4'(i) || ext_gnt_o !== 1'b0) begin errors++; $display("FAIL starve_wb%0d got we=%0b addr=%0h gnt=%0b exp 1/%0h/0", i, data_write1_o, write_addr1_o, ext_gnt_o, i); end
      end
      wb_req(1'b0, 4'd5, 16'h1004, 4'd0, 16'h0);
      #1;
      checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL starve_force_stall got %0b exp 1", stall_o); end
      tick();
      checks++; if (data_write1_o !== 1'b1 || write_addr1_o !== 4'd6 || write_data1_o !== 16'h6666 || ext_gnt_o !== 1'b1) begin errors++; $display("FAIL starve_ext got we=%0b %0h/%0h gnt=%0b exp 1 6/6666 1", data_write1_o, write_addr1_o, write_data1_o, ext_gnt_o); end
      ext_req_i = 1'b0;
      #1;
      checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL starve_release got %0b exp 0", stall_o); end
      tick();
      idle_inputs();
      checks++; if (write_addr1_o !== 4'd5 || write_data1_o !== 16'h1004 || ext_gnt_o !== 1'b0) begin errors++; $display("FAIL starve_wb_after got %0h/%0h gnt=%0b exp 5/1004 0", write_addr1_o, write_data1_o, ext_gnt_o); end
      tick();
   endtask

   // -------------------------------------------------------------------------
   task automatic test_addr_guard();
      wb_req(1'b0, 4'd8, 16'h0808, 4'd0, 16'h0);
      tick();
      checks++; if (data_write1_o !== 1'b0 || addr_err_o !== 1'b1 || write_addr1_o !== 4'd8) begin errors++; $display("FAIL guard_8 got we=%0b err=%0b addr=%0h exp 0/1/8", data_write1_o, addr_err_o, write_addr1_o); end
      wb_req(1'b1, 4'd9, 16'h0909, 4'd0, 16'h0F0F);
      tick();
      idle_inputs();
      checks++; if (data_write1_o !== 1'b0 || addr_err_o !== 1'b1 || pend_valid_o !== 1'b1) begin errors++; $display("FAIL guard_9 got we=%0b err=%0b pv=%0b exp 0/1/1", data_write1_o, addr_err_o, pend_valid_o); end
      tick();
      checks++; if (data_write1_o !== 1'b1 || addr_err_o !== 1'b0 || write_addr1_o !== 4'd0) begin errors++; $display("FAIL guard_b got we=%0b err=%0b addr=%0h exp 1/0/0", data_write1_o, addr_err_o, write_addr1_o); end
      @(negedge clk); #1;
      checks++; if (rf[0] !== 16'h0F0F) begin errors++; $display("FAIL guard_r0 got %0h exp 0f0f", rf[0]); end
      tick();
   endtask

   // -------------------------------------------------------------------------
   task automatic test_same_addr();
      wb_req(1'b1, 4'd7, 16'hAAAA, 4'd7, 16'h5555);
      tick();
      idle_inputs();
      @(negedge clk); #1;
      checks++; if (rf[7] !== 16'hAAAA) begin errors++; $display("FAIL same_first got R7=%0h exp aaaa", rf[7]); end
      tick();
      @(negedge clk); #1;
      checks++; if (rf[7] !== 16'h5555) begin errors++; $display("FAIL same_final got R7=%0h exp 5555", rf[7]); end
      tick();
   endtask

   // -------------------------------------------------------------------------
   task automatic rand_wb();
      wb_valid_i  = ($urandom_range(0, 99) < 70);
      wb_dual_i   = ($urandom_range(0, 99) < 30);
      wb_addr_a_i = 4'($urandom_range(0, 9));
      wb_addr_b_i = 4'($urandom_range(0, 9));
      wb_data_a_i = 16'($urandom);
      wb_data_b_i = 16'($urandom);
   endtask

   task automatic rand_ext();
      ext_req_i  = ($urandom_range(0, 99) < 35);
      ext_addr_i = 4'($urandom_range(0, 9));
      ext_data_i = 16'($urandom);
   endtask

   task automatic test_random();
      wr_t                 q[$];
      wr_t                 w;
      int                  denied;
      bit                  busy, must_ext, issue, gnt, take_wb, exp_stall, in_range;
      logic [3:0]          m_addr;
      logic [15:0]         m_data;
      logic [15:0]         mrf [16];
      bit                  written [16];
      m_addr = 4'd7; m_data = 16'h5555;  // last issued write of the previous scenario
      denied = 0;
      for (int r = 0; r < 16; r++) begin written[r] = 1'b0; mrf[r] = '0; end
      rand_wb(); rand_ext();
      for (int cyc = 0; cyc < 400; cyc++) begin
         #1;
         busy      = (q.size() != 0);
         must_ext  = !busy && ext_req_i && (denied >= int'(STARVE_MAX));
         exp_stall = busy || must_ext;
         checks++; if (stall_o !== exp_stall) begin errors++; $display("FAIL rnd_stall cyc%0d got %0b exp %0b", cyc, stall_o, exp_stall); end
         issue = 1'b0; gnt = 1'b0; take_wb = 1'b0;
         if (busy) begin
            w = q.pop_front(); issue = 1'b1;
         end else if (must_ext) begin
            w = '{a: ext_addr_i, d: ext_data_i}; issue = 1'b1; gnt = 1'b1;
         end else if (wb_valid_i) begin
            w = '{a: wb_addr_a_i, d: wb_data_a_i}; issue = 1'b1; take_wb = 1'b1;
            if (wb_dual_i) q.push_back('{a: wb_addr_b_i, d: wb_data_b_i});
         end else if (ext_req_i) begin
            w = '{a: ext_addr_i, d: ext_data_i}; issue = 1'b1; gnt = 1'b1;
         end
         if (!ext_req_i || gnt) denied = 0;
         else if (denied < int'(STARVE_MAX)) denied++;
         in_range = 1'b0;
         if (issue) begin
            m_addr = w.a; m_data = w.d;
            in_range = (int'(w.a) < int'(REG_NUMBER));
            if (in_range) begin mrf[w.a] = w.d; written[w.a] = 1'b1; end
         end
         @(posedge clk); #1;
         checks++; if (data_write1_o !== (issue && in_range) || addr_err_o !== (issue && !in_range)) begin errors++; $display("FAIL rnd_we cyc%0d got we=%0b err=%0b exp %0b/%0b", cyc, data_write1_o, addr_err_o, issue && in_range, issue && !in_range); end
         checks++; if (write_addr1_o !== m_addr || write_data1_o !== m_data) begin errors++; $display("FAIL rnd_port cyc%0d got %0h/%0h exp %0h/%0h", cyc, write_addr1_o, write_data1_o, m_addr, m_data); end
         checks++; if (ext_gnt_o !== gnt) begin errors++; $display("FAIL rnd_gnt cyc%0d got %0b exp %0b", cyc, ext_gnt_o, gnt); end
         checks++; if (pend_valid_o !== (q.size() != 0)) begin errors++; $display("FAIL rnd_pend cyc%0d got %0b exp %0b", cyc, pend_valid_o, q.size() != 0); end
         if (q.size() != 0) begin
            checks++; if (pend_addr_o !== q[0].a || pend_data_o !== q[0].d) begin errors++; $display("FAIL rnd_pend_data cyc%0d got %0h/%0h exp %0h/%0h", cyc, pend_addr_o, pend_data_o, q[0].a, q[0].d); end
         end
         if (take_wb || !wb_valid_i) rand_wb();
         if (gnt || !ext_req_i) rand_ext();
      end
      // Drain: hold off new requests and let any pending B issue
      idle_inputs();
      if (q.size() != 0) begin
         w = q.pop_front();
         if (int'(w.a) < int'(REG_NUMBER)) begin mrf[w.a] = w.d; written[w.a] = 1'b1; end
      end
      tick();
      @(negedge clk); #1;
      for (int r = 0; r < int'(REG_NUMBER); r++) begin
         if (written[r]) begin
            checks++; if (rf[r] !== mrf[r]) begin errors++; $display("FAIL rnd_rf R%0d got %0h exp %0h", r, rf[r], mrf[r]); end
         end
      end
      tick();
   endtask

   initial begin
      for (int r = 0; r < 16; r++) rf[r] = '0;
      test_reset();
      test_single();
      test_dual();
      test_starvation();
      test_addr_guard();
      test_same_addr();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Sequencer and arbiter for the register file's single general-purpose write port (Data_write1 / write_addr1 / write_data1). It merges two requesters: the writeback stage, which may carry a dual-destination result (SWAP-style), and an external requester (interrupt/debug context load). It serializes dual writes over two cycles, stalls writeback while doing so, and guarantees the external requester a grant within a bounded wait. It sits between the WB stage and the register file. The register file commits on the falling edge, so each write issued here lands mid-cycle.

## Interface
- REG_SIZE, 16, data width of a general register
- ADDR_W, 4, register address width
- REG_NUMBER, 8, count of general registers; addresses >= REG_NUMBER are not writable through this port (PC halves live there)
- STARVE_MAX, 4, number of consecutive denied cycles after which ext wins; range 1..15
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- wb_valid  in  1  WB stage presents a write request
- wb_dual  in  1  request carries a second write (B)
- wb_addr_a, wb_addr_b  in  ADDR_W  destination addresses
- wb_data_a, wb_data_b  in  REG_SIZE  write data
- ext_req  in  1  external requester wants the port; held until granted
- ext_addr  in  ADDR_W, ext_data  in  REG_SIZE  external write
- stall  out  1  combinational; WB stage must hold its request while high
- ext_gnt  out  1  registered one-cycle pulse; ext write issued this cycle
- Data_write1  out  1  registered register-file write enable
- write_addr1  out  ADDR_W, write_data1  out  REG_SIZE  registered write address and data
- pend_valid  out  1, pend_addr  out  ADDR_W, pend_data  out  REG_SIZE  latched B write still to issue (forwarding source)
- addr_err  out  1  registered one-cycle pulse; an issued write targeted an address >= REG_NUMBER and was suppressed

## Operation
- States: IDLE, SECOND. Counter starve_cnt, 4 bits, saturating at STARVE_MAX.
- force_ext = state==IDLE && ext_req && starve_cnt==STARVE_MAX.
- stall = (state==SECOND) || force_ext.
- IDLE priority (one write per cycle):
  1. If force_ext: issue ext; pulse ext_gnt. wb_valid is ignored; stall holds WB.
  2. Else if wb_valid: issue A.
     - If wb_dual: latch B into pend_*, pend_valid=1, go to SECOND.
  3. Else if ext_req: issue ext; pulse ext_gnt.
- SECOND:
  - Issue the latched B; clear pend_valid; go to IDLE.
  - wb_* is ignored; ext is not granted.
- starve_cnt:
  - Clear when ext_gnt is issued or when ext_req=0.
  - Otherwise increment on every cycle ext_req=1 and not granted.
- Issue means that at the next rising edge:
  - Data_write1=1, write_addr1 and write_data1 are loaded.
  - If the address is >= REG_NUMBER: Data_write1=0, addr_err=1, and address/data are still loaded for debug.
- With no issue: Data_write1=0 and write_addr1/write_data1 hold their values.
- Dual with wb_addr_a==wb_addr_b: both writes are issued in order; B is the final value.
- A suppressed A write does not suppress B.

## Timing
- Reset (rst=0, asynchronous) forces:
  - state=IDLE, starve_cnt=0;
  - Data_write1=0, write_addr1=0, write_data1=0, ext_gnt=0, addr_err=0;
  - pend_valid=0, pend_addr=0, pend_data=0.
- stall is 0 during reset.
- A reset during SECOND discards B and does not issue it.
- Latency: a request accepted at rising edge N drives the port in cycle N..N+1 and is committed by the register file at the falling edge inside that cycle.
- A dual request occupies 2 cycles: A at edge N, B at edge N+1. stall is high during cycle N..N+1, so the next WB request is accepted at edge N+2 at the earliest.
- Worst-case ext wait: STARVE_MAX denied cycles plus one possible SECOND cycle, then grant.
  - Exception: if STARVE_MAX is reached during SECOND, the grant occurs at the first IDLE cycle.
- stall depends combinationally on ext_req; upstream must use stall only as a register enable and must not feed it back into ext_req.
- pend_* is valid from the edge where A issues through the edge where B issues.

## Test plan
- Reset: assert rst=0 mid-SECOND after a dual write (A=R1/0x1111, B=R2/0x2222) -> all outputs 0 immediately, B never written, stall=0.
- Single write: wb_valid, R3/0xBEEF -> Data_write1=1, write_addr1=3, write_data1=0xBEEF one cycle later; stall never high.
- Dual write: A=R4/0x0004, B=R5/0x0005, with the next WB request held -> two consecutive writes (4 then 5); stall high for exactly one cycle; pend_valid/pend_addr=5 during that cycle; the next request issues on the third edge.
- Starvation: ext_req=1 (R6/0x6666) with wb_valid single writes every cycle, STARVE_MAX=4 -> 4 WB writes, then stall=1 and an ext write of R6 with an ext_gnt pulse; the WB request issues the following cycle.
- Address guard: wb single to addr 8, then dual A=9/B=R0 -> no Data_write1 for 8 or 9, addr_err pulsed twice, R0 written.
- Same-address dual: A=R7/0xAAAA, B=R7/0x5555 -> writes issued in order; final register value 0x5555.
